// File: rtl/fifo_axi_rr_arbiter.sv
// Packet-granular round-robin arbiter feeding fifo_4096_axi from two AXI-stream sources.
// Optional build macro FIFO_ARB_WATERMARK_EN: hold off new grants while fifo_level >= HIGH_WATER.
module fifo_axi_rr_arbiter #(
  parameter int DataWidth     = 16,
  parameter int Depth         = 4096,
  parameter int PtrWidth      = $clog2(Depth),
  parameter int HIGH_WATER    = 2048,
  parameter int MAX_PKT_BEATS = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DataWidth-1:0] s0_data,
  input  logic                 s0_valid,
  output logic                 s0_ready,
  input  logic                 s0_last,
  input  logic [DataWidth-1:0] s1_data,
  input  logic                 s1_valid,
  output logic                 s1_ready,
  input  logic                 s1_last,
  output logic [DataWidth-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last,
  input  logic [PtrWidth:0]    fifo_level,
  output logic [1:0]           grant,
  output logic [15:0]          pkt_cnt,
  output logic                 err_trunc,
  output logic [1:0]           state_dbg
);

  localparam int BW = $clog2(MAX_PKT_BEATS) + 1;
  localparam int LW = PtrWidth + 1;
  localparam logic [BW-1:0] TRUNC_AT = BW'(MAX_PKT_BEATS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, G0 = 2'd1, G1 = 2'd2} state_e;

  state_e          state_q, state_d;
  logic            rr_q, rr_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [15:0]     pkt_q, pkt_d;
  logic            err_q, err_d;
  logic            trunc;
  logic            src_last;
  logic            grant_ok;

`ifdef FIFO_ARB_WATERMARK_EN
  assign grant_ok = (fifo_level < LW'(HIGH_WATER));
`else
  logic level_unused;
  assign level_unused = ^fifo_level;
  assign grant_ok     = 1'b1;
`endif

  assign trunc = (beat_q == TRUNC_AT);

  // Handshake: a beat moves when valid & ready are both high on a rising edge; valid never
  // waits on ready. Ready is decoded from the registered owner only, so no valid->ready path.
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    beat_d   = beat_q;
    pkt_d    = pkt_q;
    err_d    = err_q;
    s0_ready = 1'b0;
    s1_ready = 1'b0;
    m_valid  = 1'b0;
    m_last   = 1'b0;
    m_data   = s0_data;
    src_last = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_ok) begin
          if (s0_valid && s1_valid) state_d = rr_q ? G0 : G1;
          else if (s0_valid)        state_d = G0;
          else if (s1_valid)        state_d = G1;
        end
      end
      G0: begin
        m_data   = s0_data;
        m_valid  = s0_valid;
        s0_ready = m_ready;
        src_last = s0_last;
        m_last   = s0_last | trunc;
      end
      G1: begin
        m_data   = s1_data;
        m_valid  = s1_valid;
        s1_ready = m_ready;
        src_last = s1_last;
        m_last   = s1_last | trunc;
      end
      default: state_d = IDLE;
    endcase

    if (m_valid && m_ready) begin
      if (m_last) begin
        // Pointer remembers the last owner so the other source wins the next tie.
        state_d = IDLE;
        rr_d    = (state_q == G1);
        beat_d  = '0;
        pkt_d   = pkt_q + 16'd1;
        if (trunc && !src_last) err_d = 1'b1;
      end else begin
        beat_d = beat_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= 1'b1;
      beat_q  <= '0;
      pkt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      beat_q  <= beat_d;
      pkt_q   <= pkt_d;
      err_q   <= err_d;
    end
  end

  assign grant     = {state_q == G1, state_q == G0};
  assign pkt_cnt   = pkt_q;
  assign err_trunc = err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_fifo_axi_rr_arbiter.sv
// Bench for fifo_axi_rr_arbiter: directed scenarios plus randomized traffic against a
// packet-level model (owner, beats into packet, packet count) fed from per-source beat queues.
module tb_fifo_axi_rr_arbiter;
  localparam int MAXB = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] s0_data = '0, s1_data = '0, m_data;
  logic        s0_valid = 1'b0, s1_valid = 1'b0, s0_last = 1'b0, s1_last = 1'b0;
  logic        s0_ready, s1_ready, m_valid, m_last, err_trunc;
  logic        m_ready = 1'b0;
  logic [12:0] fifo_level = '0;
  logic [1:0]  grant, state_dbg;
  logic [15:0] pkt_cnt;

  always #5 clk = ~clk;

  fifo_axi_rr_arbiter dut (
    .clk(clk), .rst(rst),
    .s0_data(s0_data), .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_last(s0_last),
    .s1_data(s1_data), .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_last(s1_last),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .fifo_level(fifo_level), .grant(grant), .pkt_cnt(pkt_cnt), .err_trunc(err_trunc),
    .state_dbg(state_dbg)
  );

  int errors = 0, checks = 0, cyc = 0;
  logic [16:0] q0[$], q1[$];          // {last, data} beats each source still has to deliver
  int seq0 = 0, seq1 = 0;
  int own = 0, last_src = 1, beats = 0;
  logic [15:0] exp_pkt = '0;
  logic exp_err = 1'b0;
  bit model_ok = 1'b0, pop0 = 1'b0, pop1 = 1'b0, rand_valid = 1'b0, rst_set = 1'b1;
  int ready_mode = 1;                 // 0 random, 1 always ready, 2 stalled
  logic [12:0] level_set = '0;
  int grant_log[$], grant_cyc[$];
  int trunc_beat = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic add_pkt(input int k, input int len, input bit with_last);
    for (int i = 0; i < len; i++) begin
      if (k == 0) begin q0.push_back({with_last && i == len - 1, 1'b0, seq0[14:0]}); seq0++; end
      else        begin q1.push_back({with_last && i == len - 1, 1'b1, seq1[14:0]}); seq1++; end
    end
  endtask

  task automatic drive();
    rst = rst_set;
    fifo_level = level_set;
    if (q0.size() == 0) s0_valid = 1'b0;
    else begin
      if (!s0_valid || pop0) s0_valid = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
      s0_data = q0[0][15:0];
      s0_last = q0[0][16];
    end
    if (q1.size() == 0) s1_valid = 1'b0;
    else begin
      if (!s1_valid || pop1) s1_valid = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
      s1_data = q1[0][15:0];
      s1_last = q1[0][16];
    end
    m_ready = (ready_mode == 0) ? ($urandom_range(0, 3) != 0) : (ready_mode == 1);
    pop0 = 1'b0;
    pop1 = 1'b0;
  endtask

  task automatic model();
    logic [1:0] eg;
    logic [16:0] f;
    bit v, allow, at_cap;
    at_cap = (beats == MAXB - 1);
    if (model_ok) begin
      eg = (own == 1) ? 2'b01 : (own == 2) ? 2'b10 : 2'b00;
      chk("grant", grant, eg);
      chk("s0_ready", s0_ready, (own == 1) ? m_ready : 1'b0);
      chk("s1_ready", s1_ready, (own == 2) ? m_ready : 1'b0);
      chk("m_valid", m_valid, (own == 1) ? s0_valid : (own == 2) ? s1_valid : 1'b0);
      chk("m_last", m_last, (own == 1) ? (s0_last | at_cap) : (own == 2) ? (s1_last | at_cap) : 1'b0);
      if (own != 0) chk("m_data", m_data, (own == 1) ? s0_data : s1_data);
      chk("pkt_cnt", pkt_cnt, exp_pkt);
      chk("err_trunc", err_trunc, exp_err);
    end
    if (rst) begin
      own = 0; last_src = 1; beats = 0; exp_pkt = '0; exp_err = 1'b0; model_ok = 1'b1;
    end else if (own == 0) begin
`ifdef FIFO_ARB_WATERMARK_EN
      allow = (fifo_level < 13'd2048);
`else
      allow = 1'b1;
`endif
      if (allow && (s0_valid || s1_valid)) begin
        if (s0_valid && s1_valid) own = (last_src == 0) ? 2 : 1;
        else                      own = s0_valid ? 1 : 2;
        grant_log.push_back(own);
        grant_cyc.push_back(cyc);
      end
    end else begin
      v = (own == 2) ? s1_valid : s0_valid;
      if (v && m_ready) begin
        f = (own == 2) ? q1[0] : q0[0];
        chk("beat_order", m_data, f[15:0]);
        if (own == 2) begin void'(q1.pop_front()); pop1 = 1'b1; end
        else          begin void'(q0.pop_front()); pop0 = 1'b1; end
        if (f[16] || at_cap) begin
          if (!f[16]) begin
            exp_err = 1'b1;
            if (trunc_beat < 0) trunc_beat = beats + 1;
          end
          exp_pkt  = exp_pkt + 16'd1;
          last_src = own - 1;
          own      = 0;
          beats    = 0;
        end else beats++;
      end
    end
  endtask

  task automatic step(input bit r);
    @(posedge clk);
    #1;
    rst_set = r;
    drive();
    @(negedge clk);
    cyc++;
    model();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    step(1); step(1);
    chk("t1_grant", grant, 2'b00);
    chk("t1_s0_ready", s0_ready, 1'b0);
    chk("t1_s1_ready", s1_ready, 1'b0);
    chk("t1_m_valid", m_valid, 1'b0);
    chk("t1_pkt_cnt", pkt_cnt, 16'd0);
    chk("t1_err", err_trunc, 1'b0);

    // alternating 8-beat packets, 9 cycles each
    add_pkt(0, 8, 1); add_pkt(0, 8, 1); add_pkt(1, 8, 1); add_pkt(1, 8, 1);
    grant_log.delete(); grant_cyc.delete();
    repeat (37) step(0);
    chk("t2_pkt_cnt", pkt_cnt, 16'd4);
    chk("t2_ngrants", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
      chk("t2_order", grant_log[i], (i % 2 == 0) ? 1 : 2);
      if (i > 0) chk("t2_period", grant_cyc[i] - grant_cyc[i-1], 9);
    end

    // stall 3 cycles at beat 4 of an s1 packet
    add_pkt(1, 8, 1);
    for (int i = 0; i < 20; i++) begin
      if (own == 2 && beats == 3) break;
      step(0);
    end
    chk("t3_reach", (own == 2 && beats == 3), 1'b1);
    ready_mode = 2;
    repeat (3) begin
      step(0);
      chk("t3_s1_ready", s1_ready, 1'b0);
      chk("t3_s0_ready", s0_ready, 1'b0);
      chk("t3_grant", grant, 2'b10);
      chk("t3_data", m_data, 16'h8013);
    end
    ready_mode = 1;
    repeat (8) step(0);
    chk("t3_pkt_cnt", pkt_cnt, 16'd5);

    // 300 beats with no last from s0, s1 queues up midway
    step(1); step(1);
    grant_log.delete(); trunc_beat = -1;
    add_pkt(0, 300, 0);
    repeat (200) step(0);
    add_pkt(1, 4, 1);
    repeat (120) step(0);
    chk("t4_trunc_beat", trunc_beat, 256);
    chk("t4_err", err_trunc, 1'b1);
    chk("t4_pkt_cnt", pkt_cnt, 16'd2);
    chk("t4_ngrants", grant_log.size(), 3);
    if (grant_log.size() == 3) begin
      chk("t4_g0", grant_log[0], 1);
      chk("t4_g1", grant_log[1], 2);
      chk("t4_g2", grant_log[2], 1);
    end

    // reset mid-packet
    step(1);
    step(0);
    chk("t5_grant", grant, 2'b00);
    chk("t5_pkt_cnt", pkt_cnt, 16'd0);
    chk("t5_err", err_trunc, 1'b0);
    add_pkt(0, 8, 1); add_pkt(1, 8, 1);
    for (int i = 0; i < 20; i++) begin
      if (own == 1 && beats == 2) break;
      step(0);
    end
    chk("t5_reach", (own == 1 && beats == 2), 1'b1);
    step(1);
    step(0);
    chk("t5_grant_rst", grant, 2'b00);
    chk("t5_pkt_rst", pkt_cnt, 16'd0);
    step(0);
    chk("t5_regrant", grant, 2'b01);
    repeat (40) step(0);

    // watermark
    step(1);
    q0.delete(); q1.delete();
    add_pkt(0, 8, 1); add_pkt(1, 8, 1);
    level_set = 13'd2048;
    repeat (3) step(0);
`ifdef FIFO_ARB_WATERMARK_EN
    chk("t6_hold", grant, 2'b00);
    level_set = 13'd2047;
    step(0); step(0);
    chk("t6_release", grant, 2'b01);
    level_set = 13'd4095;
    repeat (30) step(0);
    chk("t6_pkt_cnt", pkt_cnt, 16'd1);
`else
    chk("t6_ignored", grant, 2'b01);
`endif
    level_set = 13'd0;
    repeat (30) step(0);

    // randomized traffic
    step(1);
    q0.delete(); q1.delete();
    rand_valid = 1'b1;
    ready_mode = 0;
    for (int i = 0; i < 3000; i++) begin
      if (q0.size() < 3) begin
        if ($urandom_range(0, 150) == 0) add_pkt(0, 270, 0);
        else add_pkt(0, $urandom_range(1, 12), $urandom_range(0, 20) != 0);
      end
      if (q1.size() < 3) add_pkt(1, $urandom_range(1, 12), 1'b1);
      level_set = 13'($urandom_range(1900, 2200));
      step($urandom_range(0, 999) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
